instr_fetch: RTL and testbench
==============================

# instr_fetch

- Front-end stage that supplies `instr_i` to `instr_dec`.
- Keeps the fetch PC and issues word reads to instruction memory over a req/ready/rvalid handshake, with at most one read outstanding.
- Buffers returned words in a small FIFO and presents the head to the decoder, holding it while the pipeline is stalled.
- Handles control-flow redirects by flushing the buffer and discarding any stale in-flight response.

## Interface
- `ADDR_W`, 32: fetch address width (byte address).
- `RESET_PC`, 0: first fetch address after reset; bits [1:0] must be 0.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req_o` out 1: read request valid.
- `imem_addr_o` out ADDR_W: read address, always word aligned.
- `imem_ready_i` in 1: memory accepts the request this cycle.
- `imem_rvalid_i` in 1: read data valid. Arrives no earlier than 1 cycle after acceptance, in order.
- `imem_rdata_i` in 32: read data.
- `instr_o` out 32: instruction to the decoder. Equals NOP (opcode `OPCODE_NOP`, all other bits 0) when the buffer is empty.
- `instr_valid_o` out 1: `instr_o` comes from the buffer.
- `pc_o` out ADDR_W: address of `instr_o`; 0 when the buffer is empty.
- `stall_i` in 1: from pipeline control (dec conflict or mem stall); hold the head.
- `redirect_i` in 1: flush and refetch from `redirect_pc_i`.
- `redirect_pc_i` in ADDR_W: redirect target; bits [1:0] are ignored and forced to 0.

## Operation
- **State**
  - `fetch_pc`.
  - `started` flag.
  - `pending`: one read accepted, response not yet received.
  - `drop`: the pending response is stale.
  - FIFO of DEPTH entries, each holding {instr, pc}.
  - `occ` count, 0..DEPTH.
- **Reset values**
  - `fetch_pc`=RESET_PC; `started`=0; `pending`=0; `drop`=0; `occ`=0.
  - `imem_req_o`=0, `imem_addr_o`=RESET_PC, `instr_o`=NOP, `instr_valid_o`=0, `pc_o`=0.
- **Start-up:** `started` sets on the first clock edge after reset release. No request is issued while `started`=0.
- **Pop:** pop = `instr_valid_o` & !`stall_i` & !`redirect_i`.
- **Request issue**
  - `imem_req_o` = `started` & !`redirect_i` & (!`pending` | `imem_rvalid_i`) & (`occ` + (`pending` & !`drop`) − pop < DEPTH).
  - `imem_addr_o` = `fetch_pc`.
- **Accept:** when `imem_req_o` & `imem_ready_i`, `fetch_pc` += 4 (wraps modulo 2^ADDR_W) and `pending` sets.
- **Response**
  - On `imem_rvalid_i` with `pending`, `pending` clears unless a new request is accepted in the same cycle.
  - If `drop`=1, the data is discarded and `drop` clears.
  - Otherwise {`imem_rdata_i`, pc of that request} is pushed. The FIFO also records each request's pc at accept time.
  - `imem_rvalid_i` while `pending`=0 is ignored.
- **Redirect** (`redirect_i`=1 at an edge)
  - FIFO flushed; `occ`=0; `fetch_pc` = {`redirect_pc_i`[ADDR_W-1:2], 2'b00}.
  - If a request is pending and no response arrives this cycle, `drop` sets.
  - If the response arrives this same cycle, it is discarded and `drop` stays 0.
  - Redirect overrides `stall_i` and any push or pop that cycle.
- **Simultaneous push and pop:** `occ` unchanged; head advances.
- **Full buffer:** no request is issued, so an overflow is impossible by construction.

## Timing
- **Output timing:** `instr_o`, `instr_valid_o` and `pc_o` are combinational from the FIFO head; they change only at clock edges.
- **Stall:** `instr_o` is stable while `stall_i`=1.
- **Latency:** an instruction whose response arrives in cycle t is on `instr_o` in cycle t+1 if the buffer was empty.
- **Throughput:** with a single-cycle memory and no stall, DEPTH=2 sustains 1 instruction/cycle and DEPTH=1 sustains 1 per 2 cycles.
- **Redirect latency**
  - The first request to the target is issued the cycle after `redirect_i`, or after the stale response is dropped.
  - The first valid instruction appears no earlier than 2 cycles after `redirect_i`.
- **Mid-operation reset:** asserting `rst_n` low at any time returns all state to reset values immediately.
  - Memory responses after reset release with `pending`=0 are ignored.

## Configuration
- `IFETCH_PREFETCH_BUF_EN`
  - Defined: DEPTH=2, so the next fetch overlaps consumption of the current one.
  - Undefined: DEPTH=1, a single holding register; otherwise identical behaviour and ports.

## Test plan
- **Reset and start-up:** hold `rst_n` low 3 cycles, RESET_PC=0x100, memory ready=1 with 1-cycle latency -> `imem_req_o`=0 for the first cycle after release, then addresses 0x100, 0x104, 0x108… Instructions reach `instr_o` in order with matching `pc_o`; with `IFETCH_PREFETCH_BUF_EN`, one per cycle.
- **Stall hold:** `stall_i`=1 for 4 cycles while head = 0x12345678 at pc 0x104 -> `instr_o` and `pc_o` constant. No request is issued once the buffer is full (`occ` = DEPTH). Fetch resumes after release with no loss or duplication.
- **Redirect with in-flight read:** request 0x108 accepted, `redirect_i` with target 0x203 before rvalid -> the 0x108 data is discarded and the buffer is empty. The next request goes to 0x200.
- **Redirect coincident with rvalid:** that response is discarded, `drop` stays 0, and the next cycle requests the target.
- **Backpressure:** `imem_ready_i`=0 for 5 cycles -> `imem_req_o` and `imem_addr_o` held stable. `instr_o`=NOP with `instr_valid_o`=0 once drained.
- **Address wrap:** ADDR_W=8, RESET_PC=0xFC -> fetch addresses 0xFC then 0x00.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: request/ready handshake plus in-order read data.
// master = fetch unit, slave = memory.
interface instr_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (output req, addr, input ready, rvalid, rdata);
  modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC, single-outstanding memory reads, small instruction buffer.
// Define IFETCH_PREFETCH_BUF_EN for a 2-entry buffer; the default is a single holding register.
module instr_fetch #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [6:0]        OPCODE_NOP = 7'h13
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_fetch_if.master     imem,
  output logic [31:0]       instr_o,
  output logic              instr_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);

`ifdef IFETCH_PREFETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = {25'd0, OPCODE_NOP};

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              started;
  logic              pending;
  logic              drop;
  logic [OCC_W-1:0]  occ;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  logic              pop;
  logic              push;
  logic              resp;
  logic              accept;
  logic [OCC_W:0]    level;
  logic              unused_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign instr_valid_o = (occ != '0);
  assign instr_o       = instr_valid_o ? instr_mem[rd_ptr] : NOP;
  assign pc_o          = instr_valid_o ? pc_mem[rd_ptr] : '0;

  assign pop  = instr_valid_o & ~stall_i & ~redirect_i;
  assign resp = imem.rvalid & pending;
  assign push = resp & ~drop & ~redirect_i;

  // Projected fill after this cycle, counting a live in-flight read as already occupying a slot.
  assign level = {1'b0, occ} + {{OCC_W{1'b0}}, pending & ~drop} - {{OCC_W{1'b0}}, pop};

  assign imem.req  = started & ~redirect_i & (~pending | imem.rvalid) &
                     (level < (OCC_W + 1)'(DEPTH));
  assign imem.addr = fetch_pc;
  assign accept    = imem.req & imem.ready;

  assign unused_bits = ^redirect_pc_i[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      started  <= 1'b0;
      pending  <= 1'b0;
      drop     <= 1'b0;
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      started <= 1'b1;
      if (redirect_i) begin
        // A response landing this same cycle is simply discarded; otherwise mark it stale.
        fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
        pending  <= pending & ~imem.rvalid;
        drop     <= pending & ~imem.rvalid;
        occ      <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + ADDR_W'(4);
          req_pc   <= fetch_pc;
          pending  <= 1'b1;
        end else if (resp) begin
          pending <= 1'b0;
        end
        if (resp && drop) begin
          drop <= 1'b0;
        end
        if (push) begin
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        occ <= occ + OCC_W'(push) - OCC_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem.rdata;
      pc_mem[wr_ptr]    <= req_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle table for start-up/stall, then hand sequences for
// redirects, backpressure, mid-run reset and 8-bit address wrap.
module tb_instr_fetch;

`ifdef IFETCH_PREFETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] rpc;
  logic [31:0] instr;
  logic        valid;
  logic [31:0] pc;
  logic        ready;
  logic        inj;
  int          lat;

  logic [31:0] instr2;
  logic        valid2;
  logic [7:0]  pc2;

  int errors = 0;
  int checks = 0;

  instr_fetch_if #(.ADDR_W(32)) bus ();
  instr_fetch_if #(.ADDR_W(8))  bus2 ();

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'h100), .OPCODE_NOP(7'h13)) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus),
    .instr_o(instr), .instr_valid_o(valid), .pc_o(pc),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(rpc)
  );

  instr_fetch #(.ADDR_W(8), .RESET_PC(8'hFC), .OPCODE_NOP(7'h13)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem(bus2),
    .instr_o(instr2), .instr_valid_o(valid2), .pc_o(pc2),
    .stall_i(1'b0), .redirect_i(1'b0), .redirect_pc_i(8'h00)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h104) ? 32'h1234_5678 : {16'hC0DE, a[15:0]};
  endfunction

  // Memory model: lat cycles from acceptance to rvalid, one read at a time.
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] saved;
  logic        busy;
  int          cnt;
  assign bus.ready  = ready;
  assign bus.rvalid = mem_rvalid | inj;
  assign bus.rdata  = mem_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      saved      <= '0;
      busy       <= 1'b0;
      cnt        <= 0;
    end else begin
      mem_rvalid <= 1'b0;
      if (busy) begin
        if (cnt == 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= saved;
          busy       <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (bus.req && bus.ready) begin
        if (lat == 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= mdata(bus.addr);
        end else begin
          busy  <= 1'b1;
          cnt   <= lat - 1;
          saved <= mdata(bus.addr);
        end
      end
    end
  end

  assign bus2.ready = 1'b1;
  logic       mem2_rvalid;
  logic [7:0] mem2_addr;
  assign bus2.rvalid = mem2_rvalid;
  assign bus2.rdata  = {24'h0, mem2_addr};
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem2_rvalid <= 1'b0;
      mem2_addr   <= '0;
    end else begin
      mem2_rvalid <= bus2.req;
      mem2_addr   <= bus2.addr;
    end
  end

  typedef struct {
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];
  int   nvec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    rpc      = '0;
    inj      = 1'b0;
    ready    = 1'b1;
    lat      = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_accept(input logic [31:0] a, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 80 && !ok; n++) begin
      @(negedge clk);
      if (bus.req && bus.ready && bus.addr == a) ok = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] p);
    chk({tag, " valid"}, 32'(valid), 32'(v));
    chk({tag, " instr"}, instr, ins);
    chk({tag, " pc"}, pc, p);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end, expected end");
    $fatal(1, "timeout");
  end

  initial begin
    bit         ok;
    int         nacc;
    logic [7:0] accs [3];
    bit         gotv;
    logic [7:0] fpc;
    logic [31:0] finstr;

    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; rpc = '0;
    ready = 1'b1; inj = 1'b0; lat = 1;

`ifdef IFETCH_PREFETCH_BUF_EN
    nvec = 11;
    vecs[0]  = '{1'b0, 1'b0, 32'h100, 1'b0, NOP,          32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h100, 1'b0, NOP,          32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h104, 1'b0, NOP,          32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h108, 1'b1, 32'hC0DE0100, 32'h100};
    vecs[4]  = '{1'b1, 1'b0, 32'h10C, 1'b1, 32'h12345678, 32'h104};
    vecs[5]  = '{1'b1, 1'b0, 32'h10C, 1'b1, 32'h12345678, 32'h104};
    vecs[6]  = '{1'b1, 1'b0, 32'h10C, 1'b1, 32'h12345678, 32'h104};
    vecs[7]  = '{1'b1, 1'b0, 32'h10C, 1'b1, 32'h12345678, 32'h104};
    vecs[8]  = '{1'b0, 1'b1, 32'h10C, 1'b1, 32'h12345678, 32'h104};
    vecs[9]  = '{1'b0, 1'b1, 32'h110, 1'b1, 32'hC0DE0108, 32'h108};
    vecs[10] = '{1'b0, 1'b1, 32'h114, 1'b1, 32'hC0DE010C, 32'h10C};
`else
    nvec = 12;
    vecs[0]  = '{1'b0, 1'b0, 32'h100, 1'b0, NOP,          32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h100, 1'b0, NOP,          32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h104, 1'b0, NOP,          32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h104, 1'b1, 32'hC0DE0100, 32'h100};
    vecs[4]  = '{1'b0, 1'b0, 32'h108, 1'b0, NOP,          32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h108, 1'b1, 32'h12345678, 32'h104};
    vecs[6]  = '{1'b1, 1'b0, 32'h108, 1'b1, 32'h12345678, 32'h104};
    vecs[7]  = '{1'b1, 1'b0, 32'h108, 1'b1, 32'h12345678, 32'h104};
    vecs[8]  = '{1'b1, 1'b0, 32'h108, 1'b1, 32'h12345678, 32'h104};
    vecs[9]  = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h12345678, 32'h104};
    vecs[10] = '{1'b0, 1'b0, 32'h10C, 1'b0, NOP,          32'h0};
    vecs[11] = '{1'b0, 1'b1, 32'h10C, 1'b1, 32'hC0DE0108, 32'h108};
`endif

    // Reset values while rst_n is held low.
    @(negedge clk);
    chk("reset req", 32'(bus.req), 32'h0);
    chk("reset addr", bus.addr, 32'h100);
    chk_out("reset", 1'b0, NOP, 32'h0);
    chk("reset addr wrap-dut", 32'(bus2.addr), 32'hFC);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      stall = vecs[i].stall;
      @(negedge clk);
      $display("row %0d: stall=%0b req=%0b addr=%h valid=%0b instr=%h pc=%h",
               i, stall, bus.req, bus.addr, valid, instr, pc);
      chk($sformatf("row%0d req", i), 32'(bus.req), 32'(vecs[i].exp_req));
      chk($sformatf("row%0d addr", i), bus.addr, vecs[i].exp_addr);
      chk_out($sformatf("row%0d", i), vecs[i].exp_valid, vecs[i].exp_instr, vecs[i].exp_pc);
      next_cycle();
    end
    stall = 1'b0;

    // Mid-run asynchronous reset, then stray rvalid with nothing pending.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset req", 32'(bus.req), 32'h0);
    chk("midreset addr", bus.addr, 32'h100);
    chk_out("midreset", 1'b0, NOP, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    inj   = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("stray rvalid c1 valid", 32'(valid), 32'h0);
    next_cycle();
    inj = 1'b0;
    @(negedge clk);
    chk("stray rvalid c2 valid", 32'(valid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk_out("post-reset first", 1'b1, 32'hC0DE0100, 32'h100);
    $display("midreset: first instr=%h pc=%h", instr, pc);

    // Redirect while a read is in flight: stale data dropped, refetch from aligned target.
    do_reset();
    lat = 3;
    wait_accept(32'h108, ok);
    chk("inflight accept 0x108 seen", 32'(ok), 32'h1);
    redirect = 1'b1;
    rpc      = 32'h203;
    @(negedge clk);
    chk("inflight redirect req", 32'(bus.req), 32'h0);
    next_cycle();
    redirect = 1'b0;
    lat      = 1;
    @(negedge clk);
    chk("inflight +1 valid", 32'(valid), 32'h0);
    chk("inflight +1 req", 32'(bus.req), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("inflight +2 req", 32'(bus.req), 32'h1);
    chk("inflight +2 addr", bus.addr, 32'h200);
    chk("inflight +2 valid", 32'(valid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("inflight +3 valid", 32'(valid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk_out("inflight target", 1'b1, 32'hC0DE0200, 32'h200);
    $display("redirect inflight: instr=%h pc=%h", instr, pc);

    // Redirect in the same cycle as the response.
    do_reset();
    lat = 2;
    wait_accept(32'h104, ok);
    chk("coincident accept 0x104 seen", 32'(ok), 32'h1);
    next_cycle();
    redirect = 1'b1;
    rpc      = 32'h300;
    @(negedge clk);
    chk("coincident redirect req", 32'(bus.req), 32'h0);
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    chk("coincident +1 req", 32'(bus.req), 32'h1);
    chk("coincident +1 addr", bus.addr, 32'h300);
    chk("coincident +1 valid", 32'(valid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("coincident +2 valid", 32'(valid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("coincident +3 valid", 32'(valid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk_out("coincident target", 1'b1, 32'hC0DE0300, 32'h300);
    $display("redirect coincident: instr=%h pc=%h", instr, pc);

    // Backpressure: request and address held while ready is low.
    do_reset();
    ready = 1'b0;
    @(negedge clk);
    chk("bp c0 req", 32'(bus.req), 32'h0);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      $display("backpressure %0d: req=%0b addr=%h valid=%0b", k, bus.req, bus.addr, valid);
      chk($sformatf("bp%0d req", k), 32'(bus.req), 32'h1);
      chk($sformatf("bp%0d addr", k), bus.addr, 32'h100);
      chk_out($sformatf("bp%0d", k), 1'b0, NOP, 32'h0);
      next_cycle();
    end
    ready = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk_out("bp release", 1'b1, 32'hC0DE0100, 32'h100);

    // 8-bit address wrap on the second instance.
    do_reset();
    nacc = 0;
    gotv = 1'b0;
    fpc = 8'h55;
    finstr = 32'h0;
    for (int k = 0; k < 3; k++) accs[k] = 8'h55;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus2.req && nacc < 3) begin
        accs[nacc] = bus2.addr;
        $display("wrap: request addr=%h", bus2.addr);
        nacc++;
      end
      if (valid2 && !gotv) begin
        gotv   = 1'b1;
        fpc    = pc2;
        finstr = instr2;
      end
      next_cycle();
    end
    chk("wrap request count", 32'(nacc), 32'd3);
    chk("wrap addr0", 32'(accs[0]), 32'hFC);
    chk("wrap addr1", 32'(accs[1]), 32'h00);
    chk("wrap addr2", 32'(accs[2]), 32'h04);
    chk("wrap first pc", 32'(fpc), 32'hFC);
    chk("wrap first instr", finstr, 32'h0000_00FC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
